twiddle_gen_multimode: RTL and testbench

Sequential, parametrised twiddle-factor generator for the multimode radix-2 DIF FFT datapath. It replaces the fixed 8-entry N=16 lookup with a quarter-wave cosine table sized for a maximum FFT length of 2^LOG2_NMAX, and supports any run-time FFT size from 8 to NMAX. For a requested (size, stage) it streams the N/2 twiddles that the stage's butterflies consume, in order. The output uses a valid/ready handshake toward the butterfly scheduler.

---
 rtl/twiddle_gen_multimode.sv | 192 +++++++++++++++++++
 tb/tb_twiddle_gen_multimode.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen_multimode.sv
`default_nettype none
// ============================================================================
// Module   : twiddle_gen_multimode
// Purpose  : Streams the N/2 twiddles of one radix-2 DIF stage (N = 8..NMAX)
//            from a quarter-wave cosine table, valid/ready output.
//            Optional macro TWIDDLE_CONJ_EN adds a conj input (IFFT twiddles).
// Revision : 1.0 - initial release
// ============================================================================
module twiddle_gen_multimode #(
   parameter int WIDTH     = 16,
   parameter int LOG2_NMAX = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [3:0]               log2n,
   input  logic [3:0]               stage,
`ifdef TWIDDLE_CONJ_EN
   input  logic                     conj,
`endif
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err,
   output logic                     tw_valid,
   input  logic                     tw_ready,
   output logic signed [WIDTH-1:0]  tw_real,
   output logic signed [WIDTH-1:0]  tw_imag,
   output logic [LOG2_NMAX-2:0]     tw_exp,
   output logic                     tw_last
);

   localparam int              c_EW   = LOG2_NMAX - 1;
   localparam int              c_NMAX = 1 << LOG2_NMAX;
   localparam int              c_Q_I  = 1 << (LOG2_NMAX - 2);
   localparam logic [c_EW-1:0] c_Q    = c_EW'(c_Q_I);
   localparam logic [3:0]      c_L4   = 4'(LOG2_NMAX);

   // Elaboration-time cos via Taylor series; argument never exceeds pi/2.
   function automatic int cos_q(input int k);
      real x, term, sum;
      x    = 6.283185307179586 * real'(k) / real'(c_NMAX);
      sum  = 1.0;
      term = 1.0;
      for (int n = 1; n <= 14; n++) begin
         term = -term * x * x / real'((2 * n - 1) * (2 * n));
         sum  = sum + term;
      end
      return $rtoi(sum * real'((64'd1 << (WIDTH - 1)) - 64'd1) + 0.5);
   endfunction

   logic signed [WIDTH-1:0] w_tbl [0:c_Q_I];

   for (genvar k = 0; k <= c_Q_I; k++) begin : g_tbl
      assign w_tbl[k] = WIDTH'(cos_q(k));
   end

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [3:0]              r_log2n, r_stage;
   logic [c_EW-1:0]         r_j;
   logic                    r_issue_done;
   logic                    r_busy, r_done, r_cfg_err;
   logic                    r_conj;
   logic                    r_p1_valid, r_p1_q, r_p1_last;
   logic [c_EW-1:0]         r_p1_e, r_p1_are, r_p1_aim;
   logic                    r_valid, r_last;
   logic signed [WIDTH-1:0] r_re, r_im;
   logic [c_EW-1:0]         r_exp;

   logic                    w_legal, w_accept, w_bad, w_adv, w_hs, w_issue, w_final;
   logic [c_EW-1:0]         w_mask, w_jlast, w_e, w_ep, w_are, w_aim;
   logic [3:0]              w_sh;
   logic                    w_q;
   logic signed [WIDTH-1:0] w_mre, w_mim;

   assign w_legal = (log2n >= 4'd3) && (log2n <= c_L4) && (stage < log2n);
   assign w_adv   = !r_valid || tw_ready;
   assign w_hs    = r_valid && tw_ready;
   assign w_final = (r_state == S_RUN) && w_hs && r_last;
   assign w_issue = (r_state == S_RUN) && !r_issue_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_bad       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_legal) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_RUN;
               end else begin
                  w_bad = 1'b1;
               end
            end
         end
         S_RUN:   if (w_final) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // e = ((j mod (N >> (stage+1))) << stage) << (LOG2_NMAX - log2n)
   assign w_mask  = c_EW'((32'd1 << (r_log2n - r_stage - 4'd1)) - 32'd1);
   assign w_jlast = c_EW'((32'd1 << (r_log2n - 4'd1)) - 32'd1);
   assign w_sh    = r_stage + (c_L4 - r_log2n);
   assign w_e     = (r_j & w_mask) << w_sh;
   assign w_q     = (w_e >= c_Q);
   assign w_ep    = w_e - c_Q;
   assign w_are   = w_q ? (c_Q - w_ep) : w_e;
   assign w_aim   = w_q ? w_ep : (c_Q - w_e);

   assign w_mre   = w_tbl[r_p1_are];
   assign w_mim   = w_tbl[r_p1_aim];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_log2n      <= '0;
         r_stage      <= '0;
         r_j          <= '0;
         r_issue_done <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_conj       <= 1'b0;
         r_p1_valid   <= 1'b0;
         r_p1_q       <= 1'b0;
         r_p1_last    <= 1'b0;
         r_p1_e       <= '0;
         r_p1_are     <= '0;
         r_p1_aim     <= '0;
         r_valid      <= 1'b0;
         r_last       <= 1'b0;
         r_re         <= '0;
         r_im         <= '0;
         r_exp        <= '0;
      end else begin
         r_cfg_err <= w_bad;
         r_done    <= w_final;
         if (w_accept) begin
            r_log2n      <= log2n;
            r_stage      <= stage;
            r_j          <= '0;
            r_issue_done <= 1'b0;
            r_busy       <= 1'b1;
`ifdef TWIDDLE_CONJ_EN
            r_conj       <= conj;
`else
            r_conj       <= 1'b0;
`endif
         end else begin
            if (w_final) r_busy <= 1'b0;
            if (w_adv && w_issue) begin
               r_j <= r_j + 1'b1;
               if (r_j == w_jlast) r_issue_done <= 1'b1;
            end
         end
         // Both stages move together only when the output slot is free.
         if (w_adv) begin
            r_p1_valid <= w_issue;
            if (w_issue) begin
               r_p1_e    <= w_e;
               r_p1_are  <= w_are;
               r_p1_aim  <= w_aim;
               r_p1_q    <= w_q;
               r_p1_last <= (r_j == w_jlast);
            end
            r_valid <= r_p1_valid;
            r_last  <= r_p1_valid && r_p1_last;
            r_exp   <= r_p1_e;
            r_re    <= r_p1_q ? -w_mre : w_mre;
            r_im    <= r_conj ? w_mim : -w_mim;
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign cfg_err  = r_cfg_err;
   assign tw_valid = r_valid;
   assign tw_real  = r_re;
   assign tw_imag  = r_im;
   assign tw_exp   = r_exp;
   assign tw_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen_multimode.sv
`default_nettype none
// ============================================================================
// Module   : tb_twiddle_gen_multimode
// Purpose  : Self-checking bench for twiddle_gen_multimode (scoreboard queue).
// Revision : 1.0 - initial release
// ============================================================================
module tb_twiddle_gen_multimode;

   localparam int W = 16;
   localparam int L = 6;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [3:0]          log2n = '0;
   logic [3:0]          stage = '0;
   logic                tw_ready = 1'b1;
`ifdef TWIDDLE_CONJ_EN
   logic                conj = 1'b0;
`endif
   logic                busy, done, cfg_err, tw_valid, tw_last;
   logic signed [W-1:0] tw_real, tw_imag;
   logic [L-2:0]        tw_exp;

   twiddle_gen_multimode #(.WIDTH(W), .LOG2_NMAX(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .log2n(log2n), .stage(stage),
`ifdef TWIDDLE_CONJ_EN
      .conj(conj),
`endif
      .busy(busy), .done(done), .cfg_err(cfg_err), .tw_valid(tw_valid),
      .tw_ready(tw_ready), .tw_real(tw_real), .tw_imag(tw_imag),
      .tw_exp(tw_exp), .tw_last(tw_last)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [W-1:0] re;
      logic signed [W-1:0] im;
      logic [L-2:0]        ex;
      logic                last;
   } exp_t;

   exp_t                sb[$];
   int                  checks = 0;
   int                  errors = 0;
   int                  n_hs = 0;
   logic signed [W-1:0] cap_re [0:31];
   logic signed [W-1:0] cap_im [0:31];
   logic [L-2:0]        cap_ex [0:31];
   logic                prev_last_hs = 1'b0;
   logic                prev_stall = 1'b0;
   logic [2*W+L+1:0]    held = '0;

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int rnd(input real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
   endfunction

   task automatic push_expected(input int l2n, input int stg, input bit cj);
      int   n;
      int   e;
      real  ang;
      exp_t t;
      n = 1 << l2n;
      for (int j = 0; j < n / 2; j++) begin
         e      = ((j % (n >> (stg + 1))) << stg) << (L - l2n);
         ang    = 6.283185307179586 * real'(e) / real'(1 << L);
         t.re   = W'(rnd(32767.0 * $cos(ang)));
         t.im   = W'(rnd(-32767.0 * $sin(ang)));
         if (cj) t.im = -t.im;
         t.ex   = (L-1)'(e);
         t.last = (j == n / 2 - 1);
         sb.push_back(t);
      end
   endtask

   // Output monitor: reset values, done timing, stall holding, scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_zero", 64'({busy, done, cfg_err, tw_valid, tw_real, tw_imag, tw_exp, tw_last}), 64'd0);
         prev_last_hs = 1'b0;
         prev_stall   = 1'b0;
      end else begin
         check("done_pulse", 64'(done), 64'(prev_last_hs));
         if (prev_stall)
            check("stall_hold", 64'({tw_valid, tw_real, tw_imag, tw_exp, tw_last}), 64'(held));
         if (tw_valid && tw_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_word", 64'(n_hs), -64'sd1);
            end else begin
               exp_t t;
               t = sb.pop_front();
               check("tw_real", tw_real, t.re);
               check("tw_imag", tw_imag, t.im);
               check("tw_exp", 64'(tw_exp), 64'(t.ex));
               check("tw_last", 64'(tw_last), 64'(t.last));
            end
            if (n_hs < 32) begin
               cap_re[n_hs] = tw_real;
               cap_im[n_hs] = tw_imag;
               cap_ex[n_hs] = tw_exp;
            end
            n_hs++;
         end
         prev_last_hs = tw_valid && tw_ready && tw_last;
         prev_stall   = tw_valid && !tw_ready;
         held         = {tw_valid, tw_real, tw_imag, tw_exp, tw_last};
      end
   end

   task automatic start_req(input int l2n, input int stg);
      @(posedge clk); #1;
      start = 1'b1;
      log2n = 4'(l2n);
      stage = 4'(stg);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic check_latency();
      @(negedge clk); check("lat_busy", 64'(busy), 64'd1);
                      check("lat_valid_e0", 64'(tw_valid), 64'd0);
      @(negedge clk); check("lat_valid_e1", 64'(tw_valid), 64'd0);
      @(negedge clk); check("lat_valid_e2", 64'(tw_valid), 64'd1);
   endtask

   task automatic wait_done(input int mode, input int words);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         case (mode)
            1:       tw_ready = ((c % 4) == 0) || ((c % 4) == 3);
            2:       tw_ready = 1'($urandom_range(0, 1));
            default: tw_ready = 1'b1;
         endcase
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      check("word_count", 64'(n_hs), 64'(words));
      check("sb_drained", 64'(sb.size()), 64'd0);
      tw_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_valid", 64'(tw_valid), 64'd0);

      // 1: N=16 stage 0, ready always high
      n_hs = 0; push_expected(4, 0, 1'b0);
      start_req(4, 0); check_latency(); wait_done(0, 8);
      check("t1_w0_re", cap_re[0], 64'sd32767);  check("t1_w0_im", cap_im[0], 64'sd0);
      check("t1_w2_re", cap_re[2], 64'sd23170);  check("t1_w2_im", cap_im[2], -64'sd23170);
      check("t1_w4_re", cap_re[4], 64'sd0);      check("t1_w4_im", cap_im[4], -64'sd32767);
      check("t1_w7_exp", 64'(cap_ex[7]), 64'd28);

      // 2: N=16 stage 2, random backpressure
      n_hs = 0; push_expected(4, 2, 1'b0);
      start_req(4, 2); wait_done(2, 8);
      check("t2_w1_exp", 64'(cap_ex[1]), 64'd16);
      check("t2_w1_im", cap_im[1], -64'sd32767);

      // 3: N=64 stage 0, ready pattern 1,0,0,1; a start mid-run is ignored
      n_hs = 0; push_expected(6, 0, 1'b0);
      start_req(6, 0);
      start_req(2, 0);
      @(negedge clk); check("t3_start_ignored", 64'(cfg_err), 64'd0);
      wait_done(1, 32);
      check("t3_w24_re", cap_re[24], -64'sd23170);
      check("t3_w24_im", cap_im[24], -64'sd23170);

      // 4: illegal configurations
      start_req(2, 0);
      @(negedge clk); check("t4a_cfg_err", 64'(cfg_err), 64'd1);
                      check("t4a_busy", 64'(busy), 64'd0);
      @(negedge clk); check("t4a_cfg_err_pulse", 64'(cfg_err), 64'd0);
      start_req(4, 4);
      @(negedge clk); check("t4b_cfg_err", 64'(cfg_err), 64'd1);
                      check("t4b_busy", 64'(busy), 64'd0);
      repeat (3) begin
         @(negedge clk); check("t4_no_valid", 64'(tw_valid), 64'd0);
      end

      // 5: reset mid-run, then N=8
      n_hs = 0; push_expected(4, 0, 1'b0);
      start_req(4, 0);
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (n_hs >= 5) break;
      end
      check("t5_abort_point", 64'(n_hs), 64'd5);
      rst_n = 1'b0;
      sb.delete();
      #1 check("t5_async_clear", 64'({busy, tw_valid}), 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk); check("t5_no_done", 64'(done), 64'd0);
      end
      n_hs = 0; push_expected(3, 0, 1'b0);
      start_req(3, 0); wait_done(0, 4);
      check("t5_exp1", 64'(cap_ex[1]), 64'd8);
      check("t5_exp3", 64'(cap_ex[3]), 64'd24);

`ifdef TWIDDLE_CONJ_EN
      // 6: conjugate twiddles
      n_hs = 0; push_expected(4, 0, 1'b1);
      conj = 1'b1;
      start_req(4, 0);
      conj = 1'b0;
      wait_done(0, 8);
      check("t6_w2_re", cap_re[2], 64'sd23170);  check("t6_w2_im", cap_im[2], 64'sd23170);
      check("t6_w4_re", cap_re[4], 64'sd0);      check("t6_w4_im", cap_im[4], 64'sd32767);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
